motor_drive: RTL and testbench

// - Downstream of the PID steering stage: converts signed 12-bit lft_speed/rght_speed into H-bridge PWM pairs (IN1/IN2) per motor.
// - Glitch-free duty/direction updates at PWM period boundaries, dead time on reversal, coast on !go.
// - Outputs drive the motor driver pins directly.

---
 rtl/mtr_pkg.sv | 17 +
 rtl/motor_chan.sv | 102 ++++++++++
 rtl/motor_drive.sv | 65 ++++++
 tb/tb_motor_drive.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types and helpers for the motor_drive H-bridge PWM block.
// Speed is signed SPD_W bits; the PWM counter and magnitudes are PWM_W bits.
package mtr_pkg;

    typedef enum logic [1:0] {COAST, FWD, REV, DEAD} mtr_state_t;

    localparam int PWM_W = 11;
    localparam int SPD_W = 12;

    // The most negative speed has no positive twin, so it saturates to full scale.
    function automatic logic [PWM_W-1:0] sat_mag(input logic signed [SPD_W-1:0] spd);
        logic [SPD_W-1:0] u;
        u = spd[SPD_W-1] ? (~spd + SPD_W'(1)) : spd;
        return u[SPD_W-1] ? '1 : u[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/motor_chan.sv
// One H-bridge channel: period-boundary magnitude/direction latch, dead time on reversal,
// coast on !go and registered in1/in2. MOTOR_SLEW_EN adds a per-period magnitude slew limit.
module motor_chan import mtr_pkg::*; #(
    parameter int DEAD_CYC = 32
`ifdef MOTOR_SLEW_EN
    , parameter int SLEW_STEP = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [SPD_W-1:0] speed,
    input  logic [PWM_W-1:0]        cnt,
    input  logic                    wrap,
    input  logic                    go,
    output logic                    in1,
    output logic                    in2,
    output mtr_state_t              state
);

    localparam logic [7:0] DEAD_INIT = 8'(DEAD_CYC);

    logic [PWM_W-1:0] tgt_mag;
    logic             tgt_dir;
    logic [PWM_W-1:0] mag_q;
    logic             dir_q;
    logic [PWM_W-1:0] mag_nxt;
    logic             dir_nxt;
    logic             dir_cur;
    logic [7:0]       dead_cnt;
    logic             pwm;

    assign tgt_mag = sat_mag(speed);
    assign tgt_dir = speed[SPD_W-1];
    assign pwm     = (cnt < mag_q);
    assign dir_cur = wrap ? dir_nxt : dir_q;

`ifdef MOTOR_SLEW_EN
    localparam logic [PWM_W-1:0] STEP = PWM_W'(SLEW_STEP);

    // A reversal holds the old direction until the magnitude has ramped down to zero.
    always_comb begin
        mag_nxt = mag_q;
        dir_nxt = dir_q;
        if ((dir_q != tgt_dir) && (mag_q != '0)) begin
            mag_nxt = (mag_q > STEP) ? (mag_q - STEP) : '0;
        end else begin
            dir_nxt = tgt_dir;
            if (tgt_mag > mag_q)
                mag_nxt = ((tgt_mag - mag_q) > STEP) ? (mag_q + STEP) : tgt_mag;
            else
                mag_nxt = ((mag_q - tgt_mag) > STEP) ? (mag_q - STEP) : tgt_mag;
        end
    end
`else
    assign mag_nxt = tgt_mag;
    assign dir_nxt = tgt_dir;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COAST;
            mag_q    <= '0;
            dir_q    <= 1'b0;
            dead_cnt <= '0;
            in1      <= 1'b0;
            in2      <= 1'b0;
        end else begin
            // Outputs are gated by go so coasting takes effect on the very next cycle.
            in1 <= go && (state == FWD) && pwm;
            in2 <= go && (state == REV) && pwm;
            if (wrap) begin
                mag_q <= mag_nxt;
                dir_q <= dir_nxt;
            end
            if (!go) begin
                state    <= COAST;
                dead_cnt <= '0;
`ifdef MOTOR_SLEW_EN
                mag_q    <= '0;
`endif
            end else begin
                case (state)
                    COAST: if (wrap) state <= dir_nxt ? REV : FWD;
                    FWD: if (wrap && dir_nxt) begin
                        state    <= DEAD;
                        dead_cnt <= DEAD_INIT;
                    end
                    REV: if (wrap && !dir_nxt) begin
                        state    <= DEAD;
                        dead_cnt <= DEAD_INIT;
                    end
                    DEAD: begin
                        dead_cnt <= dead_cnt - 8'd1;
                        if (dead_cnt <= 8'd1) state <= dir_cur ? REV : FWD;
                    end
                    default: state <= COAST;
                endcase
            end
        end
    end

endmodule

// File: rtl/motor_drive.sv
// Dual H-bridge PWM driver: shared 11-bit PWM counter, period strobe, two motor_chan channels.
// Define MOTOR_SLEW_EN to limit magnitude change to SLEW_STEP per PWM period.
module motor_drive import mtr_pkg::*; #(
    parameter int DEAD_CYC = 32
`ifdef MOTOR_SLEW_EN
    , parameter int SLEW_STEP = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [SPD_W-1:0] lft_speed,
    input  logic signed [SPD_W-1:0] rght_speed,
    input  logic                    go,
    output logic                    lft_in1,
    output logic                    lft_in2,
    output logic                    rght_in1,
    output logic                    rght_in2,
    output logic                    prd_strb
);

    logic [PWM_W-1:0] cnt;
    logic             wrap;
    mtr_state_t       lft_state;
    mtr_state_t       rght_state;

    assign wrap = &cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            prd_strb <= 1'b0;
        end else begin
            cnt      <= cnt + PWM_W'(1);
            prd_strb <= wrap;
        end
    end

    motor_chan #(
        .DEAD_CYC(DEAD_CYC)
`ifdef MOTOR_SLEW_EN
        , .SLEW_STEP(SLEW_STEP)
`endif
    ) u_lft (
        .clk(clk), .rst(rst), .speed(lft_speed), .cnt(cnt), .wrap(wrap), .go(go),
        .in1(lft_in1), .in2(lft_in2), .state(lft_state)
    );

    motor_chan #(
        .DEAD_CYC(DEAD_CYC)
`ifdef MOTOR_SLEW_EN
        , .SLEW_STEP(SLEW_STEP)
`endif
    ) u_rght (
        .clk(clk), .rst(rst), .speed(rght_speed), .cnt(cnt), .wrap(wrap), .go(go),
        .in1(rght_in1), .in2(rght_in2), .state(rght_state)
    );

    // A bridge input may only be driven while its channel was in FWD or REV the cycle before.
    assert property (@(posedge clk) disable iff (rst) !(lft_in1 && lft_in2) && !(rght_in1 && rght_in2));
    assert property (@(posedge clk) disable iff (rst)
        (lft_in1 || lft_in2) |-> ($past(lft_state) == FWD || $past(lft_state) == REV));
    assert property (@(posedge clk) disable iff (rst)
        (rght_in1 || rght_in2) |-> ($past(rght_state) == FWD || $past(rght_state) == REV));

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive (default build, DEAD_CYC=32): duty counts per PWM period,
// period-boundary sampling, dead time on reversal, coast on !go and asynchronous reset.
module tb_motor_drive;

    localparam int PERIOD = 2048;
    localparam int LIMIT  = 5000;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [11:0] lft_speed;
    logic signed [11:0] rght_speed;
    logic               go;
    logic               lft_in1, lft_in2, rght_in1, rght_in2, prd_strb;

    int n_checks = 0;
    int n_errors = 0;
    int both_hi  = 0;

    always #5 clk = ~clk;

    motor_drive dut (
        .clk(clk), .rst(rst), .lft_speed(lft_speed), .rght_speed(rght_speed), .go(go),
        .lft_in1(lft_in1), .lft_in2(lft_in2), .rght_in1(rght_in1), .rght_in2(rght_in2),
        .prd_strb(prd_strb)
    );

    always @(negedge clk)
        if ((lft_in1 && lft_in2) || (rght_in1 && rght_in2)) both_hi++;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!prd_strb && n < LIMIT);
    endtask

    // Called on the negedge of a strobe cycle; sample j shows the output produced by cnt==j,
    // and the last sample lands on the next strobe cycle.
    task automatic measure(input int chg_at, input logic [11:0] chg_l, input logic [11:0] chg_r,
                           output int l1, output int l2, output int r1, output int r2,
                           output int first_l2, output int first_r1);
        l1 = 0; l2 = 0; r1 = 0; r2 = 0; first_l2 = -1; first_r1 = -1;
        for (int j = 0; j < PERIOD; j++) begin
            if (j == chg_at) begin
                lft_speed  = chg_l;
                rght_speed = chg_r;
            end
            @(negedge clk);
            l1 += int'(lft_in1);
            l2 += int'(lft_in2);
            r1 += int'(rght_in1);
            r2 += int'(rght_in2);
            if (lft_in2 && first_l2 < 0) first_l2 = j;
            if (rght_in1 && first_r1 < 0) first_r1 = j;
        end
    endtask

    initial begin
        int n, hi;
        int l1, l2, r1, r2, f_l2, f_r1;

        rst = 1'b1; go = 1'b0; lft_speed = '0; rght_speed = '0;
        repeat (3) @(negedge clk);
        check("rst_lft_in1", int'(lft_in1), 0);
        check("rst_lft_in2", int'(lft_in2), 0);
        check("rst_rght_in1", int'(rght_in1), 0);
        check("rst_rght_in2", int'(rght_in2), 0);
        check("rst_strb", int'(prd_strb), 0);

        lft_speed = 12'h400; rght_speed = 12'h800; go = 1'b1;
        rst = 1'b0;
        wait_strobe(n);
        check("first_strb_lat", n, 2048);

        measure(-1, 12'h000, 12'h000, l1, l2, r1, r2, f_l2, f_r1);
        check("a_lft_in1_duty", l1, 1024);
        check("a_lft_in2_duty", l2, 0);
        check("a_rght_in1_duty", r1, 0);
        check("a_rght_in2_duty", r2, 2047);
        check("a_strb_end", int'(prd_strb), 1);

        // Asynchronous reset while lft_in1 is high.
        repeat (10) @(negedge clk);
        check("pre_rst_lft_in1", int'(lft_in1), 1);
        #1 rst = 1'b1;
        #1;
        check("async_lft_in1", int'(lft_in1), 0);
        check("async_lft_in2", int'(lft_in2), 0);
        check("async_rght_in2", int'(rght_in2), 0);
        check("async_strb", int'(prd_strb), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_strobe(n);
        check("rerst_strb_lat", n, 2048);

        // Mid-period change to 0x200 must not affect the running period.
        measure(1000, 12'h200, 12'h800, l1, l2, r1, r2, f_l2, f_r1);
        check("b_lft_in1_hold", l1, 1024);
        check("b_rght_in2_duty", r2, 2047);

        // Mid-period reversal requests on both channels.
        measure(1000, 12'hE00, 12'h300, l1, l2, r1, r2, f_l2, f_r1);
        check("c_lft_in1_duty", l1, 512);
        check("c_lft_in2_hold", l2, 0);
        check("c_rght_in2_hold", r2, 2047);

        measure(-1, 12'h000, 12'h000, l1, l2, r1, r2, f_l2, f_r1);
        check("d_lft_in1_dead", l1, 0);
        check("d_lft_in2_duty", l2, 480);
        check("d_lft_in2_first", f_l2, 32);
        check("d_rght_in1_duty", r1, 736);
        check("d_rght_in1_first", f_r1, 32);
        check("d_rght_in2_dead", r2, 0);

        measure(-1, 12'h000, 12'h000, l1, l2, r1, r2, f_l2, f_r1);
        check("e_lft_in2_duty", l2, 512);
        check("e_lft_in2_first", f_l2, 0);
        check("e_rght_in1_duty", r1, 768);

        // Drop go while rght_in1 is high, then restore it mid-period.
        repeat (100) @(negedge clk);
        check("pre_go_rght_in1", int'(rght_in1), 1);
        go = 1'b0;
        @(negedge clk);
        check("coast_rght_in1", int'(rght_in1), 0);
        check("coast_rght_in2", int'(rght_in2), 0);
        check("coast_lft_in2", int'(lft_in2), 0);
        repeat (50) @(negedge clk);
        go = 1'b1;
        hi = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            hi += int'(lft_in1 | lft_in2 | rght_in1 | rght_in2);
        end while (!prd_strb && n < LIMIT);
        check("coast_until_wrap", hi, 0);
        check("coast_strb_seen", int'(prd_strb), 1);

        // Resume straight into REV/FWD from COAST (no dead time); request speed 0 on the left.
        measure(1000, 12'h000, 12'h300, l1, l2, r1, r2, f_l2, f_r1);
        check("f_lft_in2_duty", l2, 512);
        check("f_lft_in2_first", f_l2, 0);
        check("f_rght_in1_duty", r1, 768);

        measure(-1, 12'h000, 12'h000, l1, l2, r1, r2, f_l2, f_r1);
        check("g_lft_in1_zero", l1, 0);
        check("g_lft_in2_zero", l2, 0);
        check("g_rght_in1_duty", r1, 768);

        check("never_both_high", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
